// File: rtl/ycr1_mul_sched_if.sv
// rtl/ycr1_mul_sched_if.sv - handshake bundle between two requesters, the scheduler and the multiplier
//
// Purpose: groups the requester, response and multiplier handshake signals of
// ycr1_mul_sched so they travel as one port.
// Modports:
//   slave  - the scheduler side (takes requests and multiplier results, drives
//            accepts, responses and multiplier controls)
//   master - the environment side (requesters plus the multiplier)
// Signals:
//   rq0_/rq1_ valid, op[1:0], rs1[31:0], rs2[31:0], ready  request channel
//   rs0_/rs1_ valid, ready, shared rs_data[31:0]           response channel
//   mul_valid, mul_din1[32:0], mul_din2[32:0], mul_hig,
//   mul_low, mul_rdy, mul_done                             multiplier channel
interface ycr1_mul_sched_if;
   logic        rq0_valid;
   logic [1:0]  rq0_op;
   logic [31:0] rq0_rs1;
   logic [31:0] rq0_rs2;
   logic        rq0_ready;
   logic        rq1_valid;
   logic [1:0]  rq1_op;
   logic [31:0] rq1_rs1;
   logic [31:0] rq1_rs2;
   logic        rq1_ready;
   logic        rs0_valid;
   logic        rs1_valid;
   logic [31:0] rs_data;
   logic        rs0_ready;
   logic        rs1_ready;
   logic        mul_valid;
   logic [32:0] mul_din1;
   logic [32:0] mul_din2;
   logic [31:0] mul_hig;
   logic [31:0] mul_low;
   logic        mul_rdy;
   logic        mul_done;

   modport slave (
      input  rq0_valid, rq0_op, rq0_rs1, rq0_rs2,
      input  rq1_valid, rq1_op, rq1_rs1, rq1_rs2,
      output rq0_ready, rq1_ready,
      output rs0_valid, rs1_valid, rs_data,
      input  rs0_ready, rs1_ready,
      output mul_valid, mul_din1, mul_din2, mul_done,
      input  mul_hig, mul_low, mul_rdy
   );

   modport master (
      output rq0_valid, rq0_op, rq0_rs1, rq0_rs2,
      output rq1_valid, rq1_op, rq1_rs1, rq1_rs2,
      input  rq0_ready, rq1_ready,
      input  rs0_valid, rs1_valid, rs_data,
      output rs0_ready, rs1_ready,
      input  mul_valid, mul_din1, mul_din2, mul_done,
      output mul_hig, mul_low, mul_rdy
   );
endinterface

// File: rtl/ycr1_mul_sched.sv
// rtl/ycr1_mul_sched.sv - two-requester round-robin scheduler in front of a shared multiplier
//
// Purpose: accepts one multiply at a time from two requesters (round-robin on
// ties, rq0 wins the first tie after reset), starts the multiplier with
// sign-extended 33-bit operands, captures the low or high result half and
// hands it back to the requester that issued it.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - ycr1_mul_sched_if.slave: request, response and multiplier handshakes
// Build option:
//   YCR1_MUL_SCHED_ZERO_BYPASS_EN - requests with a zero operand skip the
//   multiplier and answer 0 directly (no mul_valid / mul_done).
module ycr1_mul_sched (
   input  logic           clk,
   input  logic           rstn,
   ycr1_mul_sched_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        last_grant;
   logic        gnt_id;
   logic [1:0]  op_r;
   logic [31:0] rs1_r;
   logic [31:0] rs2_r;
   logic [31:0] res_r;
   logic        byp_r;

   logic        pick1;
   logic [1:0]  pick_op;
   logic [31:0] pick_rs1;
   logic [31:0] pick_rs2;
   logic        go_bypass;
   logic        accept;
   logic        rsp_ack;

   logic        rq0_ready_c;
   logic        rq1_ready_c;
   logic        rs0_valid_c;
   logic        rs1_valid_c;
   logic        mul_valid_c;
   logic        mul_done_c;

   // rq1 wins when alone, or on a tie when rq0 was granted last.
   assign pick1    = bus.rq1_valid & (~bus.rq0_valid | ~last_grant);
   assign pick_op  = pick1 ? bus.rq1_op  : bus.rq0_op;
   assign pick_rs1 = pick1 ? bus.rq1_rs1 : bus.rq0_rs1;
   assign pick_rs2 = pick1 ? bus.rq1_rs2 : bus.rq0_rs2;

`ifdef YCR1_MUL_SCHED_ZERO_BYPASS_EN
   assign go_bypass = (pick_rs1 == 32'd0) || (pick_rs2 == 32'd0);
`else
   assign go_bypass = 1'b0;
   assign byp_r     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      rsp_ack     = 1'b0;
      rq0_ready_c = 1'b0;
      rq1_ready_c = 1'b0;
      rs0_valid_c = 1'b0;
      rs1_valid_c = 1'b0;
      mul_valid_c = 1'b0;
      mul_done_c  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.rq0_valid || bus.rq1_valid) begin
               accept      = 1'b1;
               rq0_ready_c = ~pick1;
               rq1_ready_c = pick1;
               state_nx    = go_bypass ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mul_valid_c = 1'b1;
            state_nx    = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mul_rdy) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            rs0_valid_c = ~gnt_id;
            rs1_valid_c = gnt_id;
            rsp_ack     = gnt_id ? bus.rs1_ready : bus.rs0_ready;
            if (rsp_ack) begin
               // a bypassed request never started the multiplier, so nothing to release
               mul_done_c = ~byp_r;
               state_nx   = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         op_r       <= 2'b00;
         rs1_r      <= 32'd0;
         rs2_r      <= 32'd0;
         res_r      <= 32'd0;
`ifdef YCR1_MUL_SCHED_ZERO_BYPASS_EN
         byp_r      <= 1'b0;
`endif
      end else begin
         if (accept) begin
            last_grant <= pick1;
            gnt_id     <= pick1;
            op_r       <= pick_op;
            rs1_r      <= pick_rs1;
            rs2_r      <= pick_rs2;
`ifdef YCR1_MUL_SCHED_ZERO_BYPASS_EN
            byp_r      <= go_bypass;
            if (go_bypass) begin
               res_r <= 32'd0;
            end
`endif
         end
         if ((state == ST_WAIT) && bus.mul_rdy) begin
            res_r <= (op_r == 2'b00) ? bus.mul_low : bus.mul_hig;
         end
      end
   end

   // IDLE is also the reset state, so the accept pulses need explicit gating
   // to stay low while rstn is held.
   assign bus.rq0_ready = rq0_ready_c & rstn;
   assign bus.rq1_ready = rq1_ready_c & rstn;
   assign bus.rs0_valid = rs0_valid_c;
   assign bus.rs1_valid = rs1_valid_c;
   assign bus.rs_data   = res_r;
   assign bus.mul_valid = mul_valid_c;
   assign bus.mul_done  = mul_done_c;

   // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL uses unsigned.
   // Operand registers only change on accept, which keeps din stable
   // from ISSUE through the mul_done cycle.
   assign bus.mul_din1 = {rs1_r[31] & ((op_r == 2'b01) | (op_r == 2'b10)), rs1_r};
   assign bus.mul_din2 = {rs2_r[31] & (op_r == 2'b01), rs2_r};

endmodule
